// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: a small word FIFO feeding a start/data/parity/stop serializer.
// Consecutive queued words go out back to back, with no idle gap between frames.
module uart_tx_stream #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          txdone,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    fsm_state
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DVW = $clog2(CLK_DIV);
  localparam int BW  = 4;
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [AW:0]    DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [DVW-1:0]         div_cnt, div_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   par_bit, par_n;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   push, pop, bit_end;
  logic [DATA_BITS-1:0]   head;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  assign in_ready   = (count < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign bit_end    = (div_cnt == DIV_LAST);
  assign fifo_count = count;
  assign busy       = !((state == ST_IDLE) && (count == '0));
  assign fsm_state  = state;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    return (PARITY == 1) ? ~p : p;
  endfunction

  always_comb begin
    state_n = state;
    div_n   = '0;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    pop     = 1'b0;
    txdone  = 1'b0;
    tx      = 1'b1;
    if (state != ST_IDLE) div_n = bit_end ? '0 : div_cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shreg_n = head;
          par_n   = calc_parity(head);
          bit_n   = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) begin
          bit_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        tx = shreg[0];
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        tx = par_bit;
        if (bit_end) begin
          bit_n   = '0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            txdone = 1'b1;
            bit_n  = '0;
            // A queued word starts its start bit on the very next clock.
            if (count != '0) begin
              pop     = 1'b1;
              shreg_n = head;
              par_n   = calc_parity(head);
              state_n = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      par_bit <= par_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
- REQ-001 SHALL have parameter CLK_DIV, default 16: clocks per serial bit; legal ≥2.
- REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal 5..9.
- REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
- REQ-004 SHALL have parameter STOP_BITS, default 1: legal 1 or 2.
- REQ-005 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of 2, ≥2.
- REQ-006 SHALL have port clk  input  1  system clock, all state on rising edge.
- REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-008 SHALL have port in_data  input  DATA_BITS  word to transmit.
- REQ-009 SHALL have port in_valid  input  1  in_data is valid.
- REQ-010 SHALL have port in_ready  output  1  FIFO can accept a word.
- REQ-011 SHALL have port tx  output  1  serial line, idle high.
- REQ-012 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
- REQ-013 SHALL have port txdone  output  1  one-cycle pulse at end of each frame.
- REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
- REQ-015 SHALL accept a word on any rising edge where in_valid && in_ready; in_ready = (fifo_count < FIFO_DEPTH), combinational from registered count.
- REQ-016 SHALL NOT accept a word when the FIFO is full; in_data is ignored while in_ready is low, and no word is dropped or overwritten.
- REQ-017 SHALL update fifo_count correctly on a simultaneous push and pop, leaving it unchanged.
- REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
- REQ-019 In IDLE with FIFO non-empty at a rising edge, SHALL pop the head word, load the shift register, drive tx=0, and enter START on that edge.
- REQ-020 A word pushed into an empty FIFO while IDLE at edge N SHALL produce tx=0 from edge N+1.
- REQ-021 Each serial bit SHALL be held exactly CLK_DIV clocks via a divider counter reset at each frame start.
- REQ-022 Bit order SHALL be: start(0), data LSB first (DATA_BITS bits), parity bit if PARITY≠0, then STOP_BITS stop bits (1).
- REQ-023 Parity SHALL be computed over all DATA_BITS bits: even gives XOR of the data; odd gives its inverse.
- REQ-024 Frame length SHALL be (1+DATA_BITS+(PARITY≠0)+STOP_BITS)×CLK_DIV clocks.
- REQ-025 txdone SHALL pulse high for exactly one clock on the last clock of the final stop bit.
- REQ-026 With the FIFO non-empty at the end of the final stop bit, the next frame's start bit SHALL begin on the following clock, with no idle gap.
- REQ-027 With the FIFO empty at frame end, the FSM SHALL return to IDLE with tx=1.
- REQ-028 busy SHALL be low only in IDLE with fifo_count=0.
- REQ-029 Words SHALL be transmitted in strict acceptance order.

Reset
- REQ-030 Asserting reset SHALL immediately force: tx=1, txdone=0, busy=0, fifo_count=0, FSM=IDLE, divider and bit counters 0, FIFO pointers 0.
- REQ-031 Reset mid-frame SHALL abandon the frame and discard FIFO contents; tx SHALL go high without completing the frame.
- REQ-032 After deassertion, in_ready SHALL read 1 and the first accepted word SHALL be transmitted per REQ-020.

Verification
- REQ-033 CLK_DIV=4, 8N1, push 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; txdone pulses on clock 40 after frame start.
- REQ-034 CLK_DIV=4, 8 data bits, PARITY=2, push 0x07 → parity bit 1; frame 44 clocks; 0x03 gives parity 0.
- REQ-035 DATA_BITS=7, PARITY=1, STOP_BITS=2, push 0x00 → start, 7 zeros, parity 1, two stop 1s; 11 bits total.
- REQ-036 FIFO_DEPTH=4, hold in_valid with 6 words 0x01..0x06 → in_ready drops when fifo_count=4; all 6 words sent in order with back-to-back frames and no gap; 6 txdone pulses.
- REQ-037 Assert reset at the 3rd data bit with 2 words queued → tx=1 and fifo_count=0 in the same cycle; no txdone; a new word after release transmits normally.
